// File: rtl/types_pkg.sv
// Shared payload types for the rename -> dispatch -> issue path.
package types_pkg;

  localparam int unsigned TAG_W = 7;
  localparam int unsigned ROB_W = 6;
  localparam int unsigned IMM_W = 32;
  localparam int unsigned OP_W  = 7;

  // Renamed instruction as produced by rename and carried to the issue queues
  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [ROB_W-1:0] rob_idx;
    logic [IMM_W-1:0] imm;
    logic [TAG_W-1:0] pd_new;
    logic [TAG_W-1:0] ps1;
    logic [TAG_W-1:0] ps2;
    logic             fu_alu;
    logic             fu_br;
    logic             fu_mem;
  } rename_data;

endpackage

// File: rtl/dispatch_if.sv
// Dispatch bus: rename handshake in, writeback broadcasts, flush, issue-queue handshakes out.
interface dispatch_if #(
  parameter int unsigned NUM_WB = 3
);

  localparam int unsigned TAG_W = types_pkg::TAG_W;

  logic                              valid_in;
  types_pkg::rename_data             data_in;
  logic                              ready_in;
  logic [NUM_WB-1:0]                 wb_valid;
  logic [NUM_WB-1:0][TAG_W-1:0]      wb_tag;
  logic                              mispredict;
  types_pkg::rename_data             data_out;
  logic                              ps1_rdy;
  logic                              ps2_rdy;
  logic                              alu_valid;
  logic                              br_valid;
  logic                              mem_valid;
  logic                              alu_ready;
  logic                              br_ready;
  logic                              mem_ready;

  // Upstream/downstream environment side (rename, CDB, ROB, issue queues)
  modport master (
    output valid_in, data_in, wb_valid, wb_tag, mispredict,
           alu_ready, br_ready, mem_ready,
    input  ready_in, data_out, ps1_rdy, ps2_rdy,
           alu_valid, br_valid, mem_valid
  );

  // Dispatch stage side
  modport slave (
    input  valid_in, data_in, wb_valid, wb_tag, mispredict,
           alu_ready, br_ready, mem_ready,
    output ready_in, data_out, ps1_rdy, ps2_rdy,
           alu_valid, br_valid, mem_valid
  );

endinterface

// File: rtl/dispatch.sv
// Dispatch stage: busy-table lookup for source readiness, destination busy marking,
// and a single registered output slot routed one-hot to the ALU, branch or memory queue.
// Optional macro DISPATCH_WB_BYPASS_EN: same-cycle writeback broadcasts also count
// as ready when a packet is accepted.
module dispatch #(
  parameter int unsigned PREGS  = 128,
  parameter int unsigned NUM_WB = 3
) (
  input  logic       clk,
  input  logic       reset,
  dispatch_if.slave  disp
);

  localparam int unsigned TAG_W = types_pkg::TAG_W;

  // Physical-register busy table
  logic [PREGS-1:0]      r_busy;
  logic [PREGS-1:0]      w_busy_nxt;

  // Output slot
  types_pkg::rename_data r_data;
  logic                  r_ps1_rdy;
  logic                  r_ps2_rdy;
  logic                  r_alu_valid;
  logic                  r_br_valid;
  logic                  r_mem_valid;

  types_pkg::rename_data w_data_nxt;
  logic                  w_ps1_rdy_nxt;
  logic                  w_ps2_rdy_nxt;
  logic                  w_alu_valid_nxt;
  logic                  w_br_valid_nxt;
  logic                  w_mem_valid_nxt;

  logic                  w_out_valid;
  logic                  w_out_fire;
  logic                  w_ready_in;
  logic                  w_accept;
  logic                  w_ps1_rdy_acc;
  logic                  w_ps2_rdy_acc;
  logic                  w_hold_hit_ps1;
  logic                  w_hold_hit_ps2;

  assign w_out_valid = r_alu_valid | r_br_valid | r_mem_valid;
  assign w_out_fire  = (r_alu_valid & disp.alu_ready)
                     | (r_br_valid  & disp.br_ready)
                     | (r_mem_valid & disp.mem_ready);
  assign w_ready_in  = !disp.mispredict && (!w_out_valid || w_out_fire);
  assign w_accept    = disp.valid_in && w_ready_in;

  // Writeback matches against the sources of the packet currently held in the slot
  always_comb begin
    w_hold_hit_ps1 = 1'b0;
    w_hold_hit_ps2 = 1'b0;
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      if (disp.wb_valid[k] && (disp.wb_tag[k] != '0)) begin
        if (disp.wb_tag[k] == r_data.ps1) w_hold_hit_ps1 = 1'b1;
        if (disp.wb_tag[k] == r_data.ps2) w_hold_hit_ps2 = 1'b1;
      end
    end
  end

`ifdef DISPATCH_WB_BYPASS_EN
  logic w_byp_hit_ps1;
  logic w_byp_hit_ps2;

  // Same-cycle CDB match against the incoming packet's sources
  always_comb begin
    w_byp_hit_ps1 = 1'b0;
    w_byp_hit_ps2 = 1'b0;
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      if (disp.wb_valid[k] && (disp.wb_tag[k] != '0)) begin
        if (disp.wb_tag[k] == disp.data_in.ps1) w_byp_hit_ps1 = 1'b1;
        if (disp.wb_tag[k] == disp.data_in.ps2) w_byp_hit_ps2 = 1'b1;
      end
    end
  end

  assign w_ps1_rdy_acc = !r_busy[disp.data_in.ps1] || w_byp_hit_ps1;
  assign w_ps2_rdy_acc = !r_busy[disp.data_in.ps2] || w_byp_hit_ps2;
`else
  assign w_ps1_rdy_acc = !r_busy[disp.data_in.ps1];
  assign w_ps2_rdy_acc = !r_busy[disp.data_in.ps2];
`endif

  // Busy-table update: writeback clears first, then a new allocation sets (set wins)
  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      if (disp.wb_valid[k] && (disp.wb_tag[k] != '0)) begin
        w_busy_nxt[disp.wb_tag[k]] = 1'b0;
      end
    end
    if (w_accept && (disp.data_in.pd_new != '0)) begin
      w_busy_nxt[disp.data_in.pd_new] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Busy-table register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Output-slot next state: flush, load, drain, or hold with wakeup
  always_comb begin
    w_data_nxt      = r_data;
    w_ps1_rdy_nxt   = r_ps1_rdy;
    w_ps2_rdy_nxt   = r_ps2_rdy;
    w_alu_valid_nxt = r_alu_valid;
    w_br_valid_nxt  = r_br_valid;
    w_mem_valid_nxt = r_mem_valid;

    if (disp.mispredict) begin
      w_alu_valid_nxt = 1'b0;
      w_br_valid_nxt  = 1'b0;
      w_mem_valid_nxt = 1'b0;
    end else if (w_accept) begin
      w_data_nxt      = disp.data_in;
      w_ps1_rdy_nxt   = w_ps1_rdy_acc;
      w_ps2_rdy_nxt   = w_ps2_rdy_acc;
      w_mem_valid_nxt = disp.data_in.fu_mem;
      w_br_valid_nxt  = !disp.data_in.fu_mem && disp.data_in.fu_br;
      w_alu_valid_nxt = !disp.data_in.fu_mem && !disp.data_in.fu_br;
    end else if (w_out_fire) begin
      w_alu_valid_nxt = 1'b0;
      w_br_valid_nxt  = 1'b0;
      w_mem_valid_nxt = 1'b0;
    end else if (w_out_valid) begin
      w_ps1_rdy_nxt   = r_ps1_rdy | w_hold_hit_ps1;
      w_ps2_rdy_nxt   = r_ps2_rdy | w_hold_hit_ps2;
    end
  end

  // Output-slot register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data      <= '0;
      r_ps1_rdy   <= 1'b0;
      r_ps2_rdy   <= 1'b0;
      r_alu_valid <= 1'b0;
      r_br_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
    end else begin
      r_data      <= w_data_nxt;
      r_ps1_rdy   <= w_ps1_rdy_nxt;
      r_ps2_rdy   <= w_ps2_rdy_nxt;
      r_alu_valid <= w_alu_valid_nxt;
      r_br_valid  <= w_br_valid_nxt;
      r_mem_valid <= w_mem_valid_nxt;
    end
  end

  assign disp.ready_in  = w_ready_in;
  assign disp.data_out  = r_data;
  assign disp.ps1_rdy   = r_ps1_rdy;
  assign disp.ps2_rdy   = r_ps2_rdy;
  assign disp.alu_valid = r_alu_valid;
  assign disp.br_valid  = r_br_valid;
  assign disp.mem_valid = r_mem_valid;

endmodule

// File: tb/tb_dispatch.sv
// Directed bench for the dispatch stage; honours DISPATCH_WB_BYPASS_EN for the bypass case.
module tb_dispatch;

  localparam int unsigned NUM_WB = 3;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  types_pkg::rename_data pkt_g;

  dispatch_if #(.NUM_WB(NUM_WB)) bus ();

  dispatch #(.PREGS(128), .NUM_WB(NUM_WB)) u_dut (
    .clk   (clk),
    .reset (reset),
    .disp  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] pd, input logic [6:0] s1, input logic [6:0] s2,
                      input logic alu, input logic br, input logic mem);
    types_pkg::rename_data p;
    p         = '0;
    p.opcode  = 7'h33;
    p.rob_idx = 6'(pd);
    p.imm     = {25'h0, pd};
    p.pd_new  = pd;
    p.ps1     = s1;
    p.ps2     = s2;
    p.fu_alu  = alu;
    p.fu_br   = br;
    p.fu_mem  = mem;
    bus.data_in  = p;
    bus.valid_in = 1'b1;
  endtask

  task automatic wb(input int unsigned port, input logic [6:0] tag);
    bus.wb_valid[port] = 1'b1;
    bus.wb_tag[port]   = tag;
  endtask

  task automatic wb_off();
    bus.wb_valid = '0;
    bus.wb_tag   = '0;
  endtask

  initial begin
    logic exp_byp;
    n_tests = 0;
    n_fail  = 0;
    reset          = 1'b1;
    bus.valid_in   = 1'b0;
    bus.data_in    = '0;
    bus.wb_valid   = '0;
    bus.wb_tag     = '0;
    bus.mispredict = 1'b0;
    bus.alu_ready  = 1'b1;
    bus.br_ready   = 1'b1;
    bus.mem_ready  = 1'b1;
    tick();
    tick();

    chk("rst_alu_valid", 96'(bus.alu_valid), 96'(0));
    chk("rst_br_valid",  96'(bus.br_valid),  96'(0));
    chk("rst_mem_valid", 96'(bus.mem_valid), 96'(0));
    chk("rst_ps1_rdy",   96'(bus.ps1_rdy),   96'(0));
    chk("rst_ps2_rdy",   96'(bus.ps2_rdy),   96'(0));
    chk("rst_data_out",  96'(bus.data_out),  96'(0));
    reset = 1'b0;
    #1;
    chk("idle_ready_in", 96'(bus.ready_in), 96'(1));

    // A: pd 40, sources 5 and 0 both ready
    send(7'd40, 7'd5, 7'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("a_alu_valid", 96'(bus.alu_valid), 96'(1));
    chk("a_ps1_rdy",   96'(bus.ps1_rdy),   96'(1));
    chk("a_ps2_rdy",   96'(bus.ps2_rdy),   96'(1));
    chk("a_pd_new",    96'(bus.data_out.pd_new), 96'(40));

    // B: ps1 = 40 now busy
    send(7'd41, 7'd40, 7'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b_ps1_rdy",   96'(bus.ps1_rdy),   96'(0));
    chk("b_ps2_rdy",   96'(bus.ps2_rdy),   96'(1));
    chk("b_alu_valid", 96'(bus.alu_valid), 96'(1));

    // Writeback of 40, nothing offered; B drains
    bus.valid_in = 1'b0;
    wb(0, 7'd40);
    tick();
    wb_off();
    chk("drain_alu_valid", 96'(bus.alu_valid), 96'(0));

    // C: ps1 = 40 ready again
    send(7'd42, 7'd40, 7'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("c_ps1_rdy", 96'(bus.ps1_rdy), 96'(1));

    // D re-allocates 40, E reads it while port 1 broadcasts 40
    send(7'd40, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    tick();
    send(7'd44, 7'd0, 7'd40, 1'b1, 1'b0, 1'b0);
    wb(1, 7'd40);
    tick();
    wb_off();
`ifdef DISPATCH_WB_BYPASS_EN
    exp_byp = 1'b1;
`else
    exp_byp = 1'b0;
`endif
    chk("e_bypass_ps2_rdy", 96'(bus.ps2_rdy), 96'(exp_byp));
    chk("e_ps1_rdy",        96'(bus.ps1_rdy), 96'(1));

    // F: 40 cleared by the broadcast; allocates 45
    send(7'd45, 7'd40, 7'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("f_ps1_rdy", 96'(bus.ps1_rdy), 96'(1));

    // G: branch stalled by br_ready=0 for 3 cycles, waiting on 45
    bus.br_ready = 1'b0;
    send(7'd46, 7'd45, 7'd0, 1'b0, 1'b1, 1'b0);
    tick();
    pkt_g = bus.data_in;
    chk("g_br_valid",  96'(bus.br_valid),  96'(1));
    chk("g_alu_valid", 96'(bus.alu_valid), 96'(0));
    chk("g_ps1_rdy",   96'(bus.ps1_rdy),   96'(0));
    send(7'd47, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("stall1_ready_in", 96'(bus.ready_in), 96'(0));
    wb(2, 7'd45);
    tick();
    wb_off();
    chk("stall2_br_valid", 96'(bus.br_valid), 96'(1));
    chk("stall2_data_out", 96'(bus.data_out), 96'(pkt_g));
    chk("stall2_wakeup",   96'(bus.ps1_rdy),  96'(1));
    tick();
    chk("stall3_br_valid", 96'(bus.br_valid), 96'(1));
    chk("stall3_data_out", 96'(bus.data_out), 96'(pkt_g));
    chk("stall3_ready_in", 96'(bus.ready_in), 96'(0));
    bus.br_ready = 1'b1;
    #1;
    chk("release_ready_in", 96'(bus.ready_in), 96'(1));
    tick();
    chk("h_alu_valid", 96'(bus.alu_valid), 96'(1));
    chk("h_br_valid",  96'(bus.br_valid),  96'(0));
    chk("h_pd_new",    96'(bus.data_out.pd_new), 96'(47));

    // I: mem and br flags both set -> memory queue
    send(7'd48, 7'd0, 7'd0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("i_mem_valid", 96'(bus.mem_valid), 96'(1));
    chk("i_br_valid",  96'(bus.br_valid),  96'(0));

    // Mispredict while I is held; J (pd 50) offered and must be dropped
    bus.mem_ready  = 1'b0;
    bus.mispredict = 1'b1;
    send(7'd50, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("flush_ready_in", 96'(bus.ready_in), 96'(0));
    tick();
    bus.mispredict = 1'b0;
    bus.mem_ready  = 1'b1;
    chk("flush_valids", 96'({bus.alu_valid, bus.br_valid, bus.mem_valid}), 96'(0));

    // K: 50 must not have been marked busy
    send(7'd51, 7'd50, 7'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("k_ps1_rdy",   96'(bus.ps1_rdy),   96'(1));
    chk("k_alu_valid", 96'(bus.alu_valid), 96'(1));

    // L allocates 60 in the same cycle 60 is broadcast: set wins
    send(7'd60, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    wb(0, 7'd60);
    tick();
    wb_off();
    send(7'd61, 7'd60, 7'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("m_ps1_rdy", 96'(bus.ps1_rdy), 96'(0));

    // N: pd 0 with no unit flags -> ALU; O reads preg 0
    send(7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("n_alu_valid", 96'(bus.alu_valid), 96'(1));
    send(7'd62, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("o_ps1_rdy", 96'(bus.ps1_rdy), 96'(1));
    chk("o_ps2_rdy", 96'(bus.ps2_rdy), 96'(1));

    // Reset mid-operation with a packet (pd 63) offered
    reset = 1'b1;
    send(7'd63, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("mrst_valids",   96'({bus.alu_valid, bus.br_valid, bus.mem_valid}), 96'(0));
    chk("mrst_data_out", 96'(bus.data_out), 96'(0));
    chk("mrst_ps_rdy",   96'({bus.ps1_rdy, bus.ps2_rdy}), 96'(0));
    reset = 1'b0;
    send(7'd1, 7'd60, 7'd63, 1'b1, 1'b0, 1'b0);
    tick();
    chk("q_ps1_rdy", 96'(bus.ps1_rdy), 96'(1));
    chk("q_ps2_rdy", 96'(bus.ps2_rdy), 96'(1));
    bus.valid_in = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch.md
Name: dispatch

Overview:
- Stage directly downstream of rename.
- Accepts one renamed instruction per cycle from rename's data_out/valid_out/ready_out handshake.
- Looks up source-operand readiness in a 128-entry physical-register busy table and marks the destination busy.
- Registers the packet and presents it to exactly one of the ALU, branch or memory issue queues. Writeback broadcasts clear busy bits.

Parameters:
- PREGS, 128, number of physical registers (tag width 7).
- NUM_WB, 3, number of writeback/CDB broadcast ports.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- valid_in  input  1  rename packet valid
- data_in  input  rename_data  renamed instruction (types_pkg)
- ready_in  output  1  dispatch can accept this cycle
- wb_valid  input  NUM_WB  per-port writeback valid
- wb_tag  input  NUM_WB x 7  per-port physical destination tag
- mispredict  input  1  flush from ROB
- data_out  output  rename_data  registered packet, shared by all queues
- ps1_rdy  output  1  ps1 value available
- ps2_rdy  output  1  ps2 value available
- alu_valid  output  1  packet targets ALU queue
- br_valid  output  1  packet targets branch queue
- mem_valid  output  1  packet targets memory queue
- alu_ready  input  1  ALU queue accepts
- br_ready  input  1  branch queue accepts
- mem_ready  input  1  memory queue accepts

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled on posedge clk.
- Reset values:
  - data_out = 0; ps1_rdy = ps2_rdy = 0; alu/br/mem_valid = 0.
  - All busy bits cleared (all pregs ready).
- Output stage is a single register with one-hot target sel.
  - out_valid = alu_valid|br_valid|mem_valid.
  - out_fire = selected valid & selected ready.
- ready_in = !mispredict && (!out_valid || out_fire). Accept = valid_in && ready_in.
- Latency: packet accepted at edge N is visible at outputs after edge N. Full throughput: one packet per cycle when the target queue holds ready high.
- Routing, priority when multiple flags are set: fu_mem -> mem; else fu_br -> br; else ALU. All flags zero also routes to ALU.
- Readiness at accept:
  - psX_rdy = !busy[psX]. Preg 0 is always ready; busy[0] is never set.
  - Bypass per Optional Feature.
- Busy set: on accept with data_in.pd_new != 0, busy[pd_new] <= 1.
- Busy clear: each wb_valid[k] clears busy[wb_tag[k]]. Tag 0 is ignored. Duplicate tags across ports are harmless.
- Set and clear of the same preg in one cycle: set wins (new allocation).
- Held packet wakeup: while out_valid and not firing, a wb match on data_out.ps1/ps2 sets ps1_rdy/ps2_rdy next cycle. This applies independent of the macro.
- No accept and no fire: outputs hold stable. data_out must not change while out_valid && !out_fire.
- Mispredict:
  - Next edge clears all valid outputs.
  - ready_in = 0 that cycle; no busy set from data_in.
  - wb clears still apply.
  - Busy bits of squashed pregs are not restored; they are overwritten on reallocation.
- Reset mid-operation: outputs and busy table return to reset values at that edge, regardless of other inputs.

Optional Feature:
- Macro DISPATCH_WB_BYPASS_EN.
- Defined: at accept, psX_rdy is also 1 if any wb_valid[k] && wb_tag[k] == psX that same cycle (same-cycle CDB bypass).
- Undefined: psX_rdy reflects only the registered busy table. A same-cycle broadcast is not seen at accept and is caught by held-packet wakeup or by the issue queue.

Test Plan:
- Reset, then send rd-writing packet pd_new=7'd40, ps1=5, ps2=0, fu_alu=1 with alu_ready=1 -> next cycle alu_valid=1, ps1_rdy=1, ps2_rdy=1; busy[40]=1.
- Next packet ps1=40 -> ps1_rdy=0. Then wb_valid[0]=1, wb_tag[0]=40 -> busy[40]=0 and a subsequent ps1=40 gives ps1_rdy=1.
- Packet ps2=40 accepted in the same cycle as wb_tag[1]=40 -> ps2_rdy=1 with DISPATCH_WB_BYPASS_EN, 0 without.
- Branch packet (fu_br=1) with br_ready=0 for 3 cycles -> br_valid held, data_out stable, ready_in=0. A second valid_in is not accepted until br_ready=1, then accepted the same cycle (back-to-back).
- mem_valid high, mispredict=1 -> next cycle all valids 0. A valid_in with pd_new=50 offered that cycle leaves busy[50]=0.
- wb_valid on tag 60 and accept of pd_new=60 in the same cycle -> busy[60]=1. pd_new=0 never sets busy[0]; ps1=0 always gives ps1_rdy=1.
